// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART 8N1 transmit controller with TX FIFO, baud divider and register port.
// Define UART_TX_IRQ_EN to enable the registered TX-done interrupt; otherwise irq is tied low.
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] ctrl_div;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] baud_cnt;
    logic             tx_en;
    logic             irq_en;
    logic             ovf;
    logic [7:0]       tx_shadow;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic wr_sel, push_req, push, pop, overflow;
    logic full, empty, baud_tick, start_frame, line_next;
    logic unused_wdata;

    assign unused_wdata = ^req_wdata;

    assign wr_sel    = req_valid && req_write;
    assign push_req  = wr_sel && (req_addr == 8'h00);
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign baud_tick = (baud_cnt == div_lat);

    // A new frame starts from IDLE or straight out of a finished STOP bit.
    assign start_frame = tx_en && !empty &&
                         ((state == S_IDLE) || ((state == S_STOP) && baud_tick));
    assign pop      = start_frame;
    assign push     = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en     <= 1'b0;
            irq_en    <= 1'b0;
            ctrl_div  <= '0;
            tx_shadow <= 8'h00;
            ovf       <= 1'b0;
        end else begin
            if (push_req) tx_shadow <= req_wdata[7:0];
            if (wr_sel && (req_addr == 8'h0C)) begin
                tx_en    <= req_wdata[0];
                irq_en   <= req_wdata[1];
                ctrl_div <= req_wdata[16 +: DIV_W];
            end
            if (overflow) begin
                ovf <= 1'b1;
            end else if (wr_sel && (req_addr == 8'h08) && req_wdata[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        line_next = 1'b1;
        case (state)
            S_START: line_next = 1'b0;
            S_DATA:  line_next = shift[0];
            default: line_next = 1'b1;
        endcase
    end

    // The line register lags the state by one clock, so every bit keeps its full width.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            div_lat  <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            uart_tx  <= 1'b1;
        end else begin
            uart_tx <= line_next;
            if (start_frame) begin
                state    <= S_START;
                shift    <= mem[rd_ptr];
                div_lat  <= ctrl_div;
                baud_cnt <= '0;
                bit_idx  <= 3'd0;
            end else if (state != S_IDLE) begin
                if (baud_tick) begin
                    baud_cnt <= '0;
                    case (state)
                        S_START: state <= S_DATA;
                        S_DATA: begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= S_STOP;
                        end
                        default: state <= S_IDLE;
                    endcase
                end else begin
                    baud_cnt <= baud_cnt + DIV_W'(1);
                end
            end
        end
    end

`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= irq_en && (state == S_IDLE) && empty;
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = 32'h0;
        case (req_addr)
            8'h00: rdata = {24'h0, tx_shadow};
            8'h08: rdata = {20'h0, 4'(count), 4'h0, ovf, empty, full, (state != S_IDLE)};
            8'h0C: rdata = {16'(ctrl_div), 14'h0, irq_en, tx_en};
            default: rdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - Self-checking bench for uart_tx_ctrl against a queue-based line model.
module tb_uart_tx_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;

    uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata),
        .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp(input logic busy);
        logic [31:0] s;
        s = (32'(q.size()) << 8) | (32'(m_ovf) << 3) | 32'(busy);
        if (q.size() == 0)     s = s | 32'h4;
        if (q.size() == DEPTH) s = s | 32'h2;
        return s;
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] dat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = dat;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_wdata = 32'h0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        req_addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic [31:0] w;
        w = $urandom;
        w[7:0] = b;
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1'b1;
        wr(8'h00, w);
    endtask

    // Samples one whole frame starting at its first start-bit cycle; bit k spans clocks k*(d+1)..
    task automatic expect_frame(input logic [7:0] b, input int d, input int exp_cnt, input int clear_at);
        int n;
        n = 10 * (d + 1);
        for (int i = 0; i < n; i++) begin
            int k;
            logic e;
            if (i == clear_at + 1) begin
                req_valid = 1'b0; req_write = 1'b0; req_wdata = 32'h0;
            end
            k = i / (d + 1);
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            check($sformatf("line_b%02h_bit%0d_clk%0d", b, k, i), {31'h0, uart_tx}, {31'h0, e});
            if (i == 0) begin
                req_addr = 8'h08;
                #1;
                check("frame_count", {28'h0, rdata[11:8]}, {28'h0, exp_cnt[3:0]});
                check("frame_irq", {31'h0, irq}, 32'h0);
            end
            if (i == clear_at) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h0C;
                req_wdata = 32'(d) << 16;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int d;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd(8'h08, 32'h0000_0004, "rst_status");
        rd(8'h0C, 32'h0, "rst_ctrl");
        rd(8'h00, 32'h0, "rst_txdata");
        rd(8'h04, 32'h0, "rst_rxdata");

        wr(8'h04, 32'hFFFF_FFFF);
        rd(8'h04, 32'h0, "rxdata_ro");
        rd(8'h10, 32'h0, "unmapped");
        wr(8'h0C, 32'hABCD_0002);
        rd(8'h0C, 32'hABCD_0002, "ctrl_readback");
        wr(8'h0C, 32'h0);

        // Single frame, DIV=3
        wr(8'h0C, 32'h0003_0001);
        push_byte(8'hA5);
        rd(8'h08, status_exp(1'b0), "single_status_pushed");
        @(negedge clk);
        b = q.pop_front();
        rd(8'h08, status_exp(1'b1), "single_status_busy");
        check("single_line_pre", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        expect_frame(b, 3, q.size(), -1);
        rd(8'h08, 32'h0000_0004, "single_status_done");
        rd(8'h00, 32'h0000_00A5, "txdata_shadow");
        check("single_line_idle", {31'h0, uart_tx}, 32'h1);

        // Back-to-back frames, DIV=0
        wr(8'h0C, 32'h0);
        push_byte(8'h55);
        push_byte(8'h0F);
        push_byte(8'hFF);
        rd(8'h08, status_exp(1'b0), "b2b_status_queued");
        wr(8'h0C, 32'h0000_0001);
        rd(8'h08, status_exp(1'b0), "b2b_status_en");
        @(negedge clk);
        b = q.pop_front();
        rd(8'h08, status_exp(1'b1), "b2b_status_first_pop");
        @(negedge clk);
        expect_frame(b, 0, q.size(), -1);
        while (q.size() > 0) begin
            b = q.pop_front();
            expect_frame(b, 0, q.size(), -1);
        end
        rd(8'h08, 32'h0000_0004, "b2b_status_done");

        // Overflow with random divisor and bytes
        d = $urandom_range(0, 2);
        wr(8'h0C, 32'(d) << 16);
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
        rd(8'h08, status_exp(1'b0), "ovf_status_full");
        rd(8'h08, 32'h0000_080A, "ovf_status_literal");
        wr(8'h08, 32'h0000_0008);
        m_ovf = 1'b0;
        rd(8'h08, status_exp(1'b0), "ovf_cleared");
        wr(8'h0C, (32'(d) << 16) | 32'h1);
        @(negedge clk);
        @(negedge clk);
        while (q.size() > 0) begin
            b = q.pop_front();
            expect_frame(b, d, q.size(), -1);
        end
        for (int i = 0; i < 3 * (d + 1) + 4; i++) begin
            check("ovf_line_idle", {31'h0, uart_tx}, 32'h1);
            @(negedge clk);
        end
        rd(8'h08, 32'h0000_0004, "ovf_status_drained");

        // TX_EN cleared during data bit 4, DIV=1
        wr(8'h0C, 32'h0001_0000);
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wr(8'h0C, 32'h0001_0001);
        @(negedge clk);
        @(negedge clk);
        b = q.pop_front();
        expect_frame(b, 1, q.size(), 5 * 2);
        for (int i = 0; i < 20; i++) begin
            check("txen_off_line_high", {31'h0, uart_tx}, 32'h1);
            @(negedge clk);
        end
        rd(8'h08, status_exp(1'b0), "txen_off_status");

        // Reset during a start bit
        wr(8'h0C, 32'h0001_0001);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_line_low", {31'h0, uart_tx}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_line_high", {31'h0, uart_tx}, 32'h1);
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        rd(8'h08, 32'h0000_0004, "rst_mid_status");
        rd(8'h0C, 32'h0, "rst_mid_ctrl");

`ifdef UART_TX_IRQ_EN
        d = $urandom_range(0, 2);
        wr(8'h0C, (32'(d) << 16) | 32'h3);
        @(negedge clk);
        check("irq_idle_set", {31'h0, irq}, 32'h1);
        for (int f = 0; f < 2; f++) begin
            push_byte(8'($urandom));
            @(negedge clk);
            check("irq_drop_on_push", {31'h0, irq}, 32'h0);
            b = q.pop_front();
            @(negedge clk);
            expect_frame(b, d, q.size(), -1);
            check("irq_after_stop", {31'h0, irq}, 32'h1);
        end
`else
        wr(8'h0C, 32'h0000_0003);
        repeat (3) @(negedge clk);
        check("irq_tied_idle", {31'h0, irq}, 32'h0);
        push_byte(8'($urandom));
        @(negedge clk);
        b = q.pop_front();
        @(negedge clk);
        expect_frame(b, 0, q.size(), -1);
        check("irq_tied_after", {31'h0, irq}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller for the peripheral region at 0x4000_0200 (bus_interconnect routes the 256 B window here). It adds a TX byte FIFO, a programmable baud divider and an 8N1 serializer FSM that drives `uart_tx`. The register map keeps TXDATA, RXDATA, STATUS and CTRL at the same offsets and read semantics the firmware already uses, so it can be dropped in where the UART stub sits.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, ≥2.
- `DIV_W`, default 16: baud divisor width; ≤16.
- `clk` in 1: system clock; everything updates on the rising edge.
- `rst` in 1: reset. **Synchronous, active-high.**
- `req_valid` in 1: single-cycle bus request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8: register byte offset (upper bits already decoded by bus_interconnect).
- `req_wdata` in 32: write data; always a whole-word write.
- `rdata` out 32: combinational read mux on `req_addr`; bus_interconnect registers it.
- `uart_tx` out 1: serial line, registered output; idle level high.
- `irq` out 1: TX-done interrupt, registered output (see Configuration).

## Operation
- Registers:
  - 0x00 TXDATA.
    - Write pushes `req_wdata[7:0]`; bits [31:8] are ignored.
    - Read returns the last pushed byte, zero-extended.
  - 0x04 RXDATA: read-only, returns 0; writes are ignored.
  - 0x08 STATUS: read-only except OVF.
    - bit0 BUSY: FSM is not in IDLE.
    - bit1 FULL.
    - bit2 EMPTY.
    - bit3 OVF: sticky; a write to 0x08 with bit3 = 1 clears it.
    - bits[11:8] COUNT: FIFO occupancy.
  - 0x0C CTRL: read/write.
    - bit0 TX_EN.
    - bit1 IRQ_EN.
    - bits[31:16] DIV: bit period is DIV+1 clocks.
  - Unmapped offsets: read 0, writes ignored.
- Reset values:
  - `uart_tx`=1, `irq`=0.
  - CTRL=0, TXDATA shadow=0, OVF=0.
  - FIFO empty; STATUS reads 0x0000_0004.
- FIFO:
  - A push when COUNT=FIFO_DEPTH and no pop in the same cycle is dropped and sets OVF.
  - A push and a pop in the same cycle while full both succeed; COUNT is unchanged and OVF is not set.
- FSM states: IDLE, START, DATA, STOP. Each non-IDLE state lasts exactly DIV+1 clocks, counted by the baud counter.
  - IDLE → START when TX_EN=1 and the FIFO is not empty.
    - Pops the head into the shift register.
    - Latches DIV for the whole frame.
  - START drives 0, then → DATA.
  - DATA drives shift[0], LSB first; the bit index runs 0..7 and the FSM → STOP after bit 7.
  - STOP drives 1.
    - At its end: if TX_EN=1 and the FIFO is not empty, → START with a pop (back-to-back frames, no idle gap).
    - Otherwise → IDLE.
- Clearing TX_EN mid-frame: the current frame completes, then the FSM goes to IDLE and the FIFO is retained.
- Writing DIV mid-frame: takes effect only at the next frame start.
- Reset asserted mid-frame: the FSM goes to IDLE, the FIFO is flushed, and `uart_tx`=1 on the next clock. A truncated frame on the line is acceptable.

## Timing
- Push latency: TXDATA write in cycle N → byte is in the FIFO after edge N; COUNT is visible from cycle N+1.
- Start latency: with the FSM idle and TX_EN=1, the pop happens at edge N+1 and `uart_tx` falls after edge N+2 (registered output).
- Frame length: exactly 10×(DIV+1) clocks. Back-to-back frames are contiguous.
- BUSY: rises the cycle after the pop and falls the cycle after STOP ends with the FIFO empty.
- OVF: set at the edge of the dropped push.

## Configuration
- Macro: `UART_TX_IRQ_EN`.
- Defined:
  - `irq` is a registered level, set when IRQ_EN=1, the FSM is in IDLE and the FIFO is empty.
  - `irq` clears the cycle after any of those conditions goes false.
- Undefined:
  - `irq` is tied to 0.
  - CTRL bit1 reads back as written but has no effect.

## Test plan
- Reset / register defaults:
  - Release `rst` → `uart_tx`=1, `irq`=0.
  - STATUS=0x0000_0004; CTRL, TXDATA and RXDATA all read 0.
- Single frame:
  - Stimulus: CTRL=0x0003_0001 (DIV=3), then TXDATA=0xA5.
  - Line: `uart_tx` low 2 cycles after the write, then 0,1,0,1,0,0,1,0,1 followed by stop 1; each bit exactly 4 clocks, 40 clocks total.
  - BUSY falls after the frame.
- Back-to-back frames: DIV=0, push 0x55, 0x0F, 0xFF → 30 contiguous bit-clocks with no idle gap; COUNT steps 3→2→1→0 at frame starts.
- Overflow:
  - Stimulus: TX_EN=0, push 9 bytes into the depth-8 FIFO.
  - Expect: COUNT=8, FULL=1, OVF=1, and the 9th byte is dropped.
  - Write STATUS=0x8 → OVF=0.
  - Set TX_EN=1 → exactly 8 frames are sent.
- TX_EN cleared mid-frame:
  - Stimulus: 2 bytes queued, TX_EN cleared during bit 4 of the first frame.
  - Expect: the first frame completes, the FSM idles, COUNT=1, and the line stays high.
  - Reset asserted mid-frame → `uart_tx`=1 and COUNT=0 the next cycle.
- IRQ (with `UART_TX_IRQ_EN`):
  - IRQ_EN=1 and one byte sent → `irq`=0 during the frame, 1 after STOP ends.
  - Pushing another byte drops `irq` within 2 cycles.
